acs_path_metric: RTL and testbench
==================================

Name: acs_path_metric

Overview:
- Add-compare-select and path-metric stage of the rate-1/2, K=4 (8-state) Viterbi decoder.
- Sits directly downstream of the branch-metric blocks and consumes one set of four 2-bit branch metrics (one per codeword 00/01/10/11) per trellis step.
- Updates eight registered path metrics and emits one survivor decision bit per state to the traceback memory.
- Also reports the current best state and its metric.

Parameters:
- PM_W, 8: path-metric width in bits, unsigned.
- INIT_PM, 16: initial metric loaded into states 1..7 at reset/init; state 0 loads 0. Constraint: INIT_PM < 2^(PM_W-2).
- G1, 4'b1111: generator polynomial for codeword bit 1, applied to {u, p[2:0]}.
- G0, 4'b1101: generator polynomial for codeword bit 0, applied to {u, p[2:0]}.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- init  input  1  synchronous re-initialise of metrics, start of a new frame.
- bm_valid  input  1  branch metrics valid this cycle; one trellis step.
- bm00  input  2  branch metric for codeword 00.
- bm01  input  2  branch metric for codeword 01.
- bm10  input  2  branch metric for codeword 10.
- bm11  input  2  branch metric for codeword 11.
- dec_valid  output  1  decisions/best outputs valid; one-cycle pulse per step.
- dec  output  8  survivor decision per next-state n (bit n): 0 = predecessor p0 won, 1 = p1 won.
- best_state  output  3  index of the lowest updated metric.
- best_pm  output  PM_W  value of that metric.

Behaviour:
- Reset (async, rst=1):
  - pm[0]=0; pm[1..7]=INIT_PM.
  - dec_valid=0, dec=0, best_state=0, best_pm=0.
  - Takes effect immediately mid-operation; any step in flight is discarded.
- Trellis definition, for next state n:
  - p0={1'b0,n[2:1]}, p1={1'b1,n[2:1]}, input bit u=n[0].
  - Expected codeword from predecessor p: c1=^({u,p}&G1), c0=^({u,p}&G0). The branch metric is selected by {c1,c0}.
- Per step (bm_valid=1 and init=0), all 8 states in parallel:
  - cand0 = pm[p0] + bm(p0→n); cand1 = pm[p1] + bm(p1→n). Compute at PM_W+1 bits.
  - If cand1 < cand0: new_pm[n]=cand1, dec[n]=1. Otherwise (including tie): new_pm[n]=cand0, dec[n]=0.
- Normalisation, same cycle, after select:
  - If all eight new_pm have bit PM_W-1 set, clear bit PM_W-1 in all of them (subtract 2^(PM_W-1)) before registering.
  - Metrics never overflow PM_W bits under the parameter constraint. Any carry into bit PM_W is a design error; flag it with an assertion.
- Best state:
  - Minimum over the normalised new_pm.
  - Ties resolve to the lowest state index.
- Latency: bm_valid at edge k → pm, dec, best_state, best_pm and dec_valid=1 registered at edge k+1.
- When bm_valid=0: dec_valid=0 next cycle. pm, dec, best_state and best_pm hold their values.
- Back-to-back bm_valid is allowed every cycle, at full throughput with no stalls.
- init=1 at an edge:
  - Reloads the reset metric pattern and forces dec_valid=0, whatever bm_valid is (init has priority).
  - dec, best_state and best_pm hold their values.
- Branch metrics outside 0..2 are legal inputs and are added as given (range 0..3).

Test Plan:
- Reset then bm00=0, bm01=bm10=bm11=2, bm_valid one cycle → next cycle dec_valid=1, pm[0]=0, pm[1]=2, dec[0]=0, best_state=0, best_pm=0.
- Feed the encoded stream of an all-zero message (bm00=0, others 2) for 20 steps → best_state=0 and best_pm=0 every step; dec_valid high on every step.
- Equal candidates (all bm=0 from reset, both predecessors tied at INIT_PM) → dec bit=0 for tied states. Best-state tie among equal metrics → lowest index.
- Drive bm=3 on all codewords for 200 steps → normalisation fires repeatedly; no pm exceeds 2^PM_W-1; differences between metrics are preserved against a reference model.
- Assert rst mid-stream with bm_valid=1 → outputs are at reset values immediately. init asserted mid-stream with bm_valid=1 → metrics reload and dec_valid=0 the next cycle.
- Random encoded message with single bit errors, compared against a golden ACS model → dec, best_state and best_pm match bit-exactly every step.

Source files
------------

// File: rtl/acs_path_metric_if.sv
// acs_path_metric_if
//   Bundles the per-step branch-metric input and the per-step decision/best
//   output of the Viterbi add-compare-select stage.
//   master : upstream side, drives init/bm_valid/bm00..bm11 and observes results
//   slave  : the ACS stage, consumes branch metrics and drives dec_valid/dec/
//            best_state/best_pm
//   Signals:
//     init        synchronous re-initialise of path metrics
//     bm_valid    one trellis step offered this cycle
//     bm00..bm11  2-bit branch metrics indexed by codeword
//     dec_valid   one-cycle pulse per completed step
//     dec         survivor decision per next state
//     best_state  index of the lowest path metric
//     best_pm     value of that metric
interface acs_path_metric_if #(
  parameter int PM_W = 8
);
  logic            init;
  logic            bm_valid;
  logic [1:0]      bm00;
  logic [1:0]      bm01;
  logic [1:0]      bm10;
  logic [1:0]      bm11;
  logic            dec_valid;
  logic [7:0]      dec;
  logic [2:0]      best_state;
  logic [PM_W-1:0] best_pm;

  modport master (
    output init, bm_valid, bm00, bm01, bm10, bm11,
    input  dec_valid, dec, best_state, best_pm
  );

  modport slave (
    input  init, bm_valid, bm00, bm01, bm10, bm11,
    output dec_valid, dec, best_state, best_pm
  );
endinterface

// File: rtl/acs_path_metric.sv
// acs_path_metric
//   Add-compare-select and path-metric register stage of a rate-1/2, K=4
//   (8-state) Viterbi decoder. Each accepted step updates all eight path
//   metrics in parallel, emits one survivor decision bit per state and reports
//   the lowest metric and its state index.
//   Ports:
//     clk  rising-edge clock
//     rst  asynchronous active-high reset
//     bus  acs_path_metric_if slave (branch metrics in, decisions/best out)
module acs_path_metric #(
  parameter int         PM_W    = 8,
  parameter int         INIT_PM = 16,
  parameter logic [3:0] G1      = 4'b1111,
  parameter logic [3:0] G0      = 4'b1101
) (
  input  logic               clk,
  input  logic               rst,
  acs_path_metric_if.slave   bus
);

  localparam logic [PM_W-1:0] INIT_VAL = PM_W'(INIT_PM);

  logic [PM_W-1:0] pm       [8];
  logic [PM_W:0]   cand0    [8];
  logic [PM_W:0]   cand1    [8];
  logic [PM_W:0]   sel_pm   [8];
  logic [PM_W-1:0] norm_pm  [8];
  logic [7:0]      dec_next;
  logic            all_high;
  logic            carry;
  logic [2:0]      best_state_next;
  logic [PM_W-1:0] best_pm_next;

  logic            dec_valid_q;
  logic [7:0]      dec_q;
  logic [2:0]      best_state_q;
  logic [PM_W-1:0] best_pm_q;

  // Branch metric for the transition leaving predecessor p with input bit u:
  // the encoder register {u,p} is masked by each generator and reduced by XOR
  // to get the expected codeword, which selects one of the four metrics.
  function automatic logic [1:0] pick_bm(input logic [2:0] p, input logic u,
                                         input logic [1:0] b00, input logic [1:0] b01,
                                         input logic [1:0] b10, input logic [1:0] b11);
    logic [3:0] v;
    logic [1:0] cw;
    v  = {u, p};
    cw = {^(v & G1), ^(v & G0)};
    case (cw)
      2'b00:   pick_bm = b00;
      2'b01:   pick_bm = b01;
      2'b10:   pick_bm = b10;
      default: pick_bm = b11;
    endcase
  endfunction

  // Next state n is reached from p0={0,n[2:1]} and p1={1,n[2:1]} with input
  // bit n[0]. Candidates are one bit wider so a carry would be visible; ties
  // go to p0.
  always_comb begin
    dec_next = '0;
    carry    = 1'b0;
    for (int n = 0; n < 8; n++) begin
      cand0[n] = {1'b0, pm[3'(n >> 1)]}
               + (PM_W+1)'(pick_bm(3'(n >> 1), n[0], bus.bm00, bus.bm01, bus.bm10, bus.bm11));
      cand1[n] = {1'b0, pm[3'(n >> 1) | 3'b100]}
               + (PM_W+1)'(pick_bm(3'(n >> 1) | 3'b100, n[0], bus.bm00, bus.bm01, bus.bm10, bus.bm11));
      if (cand1[n] < cand0[n]) begin
        sel_pm[n]   = cand1[n];
        dec_next[n] = 1'b1;
      end else begin
        sel_pm[n]   = cand0[n];
      end
      carry = carry | sel_pm[n][PM_W];
    end
  end

  // When every metric has its top bit set, dropping that bit from all of them
  // subtracts the same constant and keeps the relative differences intact.
  always_comb begin
    all_high = 1'b1;
    for (int n = 0; n < 8; n++) begin
      all_high = all_high & sel_pm[n][PM_W-1];
    end
    for (int n = 0; n < 8; n++) begin
      norm_pm[n] = sel_pm[n][PM_W-1:0];
      if (all_high) begin
        norm_pm[n][PM_W-1] = 1'b0;
      end
    end
  end

  // Strict less-than while scanning upward keeps the lowest index on ties.
  always_comb begin
    best_state_next = 3'd0;
    best_pm_next    = norm_pm[0];
    for (int n = 1; n < 8; n++) begin
      if (norm_pm[n] < best_pm_next) begin
        best_state_next = 3'(n);
        best_pm_next    = norm_pm[n];
      end
    end
  end

  // init reloads the metrics and suppresses the step even when bm_valid is
  // high; decisions and best outputs keep their last values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) begin
        pm[i] <= (i == 0) ? '0 : INIT_VAL;
      end
      dec_valid_q  <= 1'b0;
      dec_q        <= '0;
      best_state_q <= '0;
      best_pm_q    <= '0;
    end else if (bus.init) begin
      for (int i = 0; i < 8; i++) begin
        pm[i] <= (i == 0) ? '0 : INIT_VAL;
      end
      dec_valid_q <= 1'b0;
    end else if (bus.bm_valid) begin
      for (int i = 0; i < 8; i++) begin
        pm[i] <= norm_pm[i];
      end
      dec_valid_q  <= 1'b1;
      dec_q        <= dec_next;
      best_state_q <= best_state_next;
      best_pm_q    <= best_pm_next;
    end else begin
      dec_valid_q <= 1'b0;
    end
  end

  assign bus.dec_valid  = dec_valid_q;
  assign bus.dec        = dec_q;
  assign bus.best_state = best_state_q;
  assign bus.best_pm    = best_pm_q;

  // A carry out of the metric width means INIT_PM or PM_W were chosen badly.
  carry_never_set: assert property (@(posedge clk) disable iff (rst)
    (bus.bm_valid && !bus.init) |-> !carry);

endmodule

// File: tb/tb_acs_path_metric.sv
// tb_acs_path_metric
//   Scoreboard bench for acs_path_metric. Stimulus computes each step's
//   expected decisions and best metric from a trellis model and queues them;
//   a monitor pops and compares whenever dec_valid is seen, and checks that
//   outputs hold while no step completes.
module tb_acs_path_metric;

  localparam int PM_W    = 8;
  localparam int INIT_PM = 16;
  localparam int HALF    = 1 << (PM_W - 1);

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  acs_path_metric_if #(.PM_W(PM_W)) bus();

  acs_path_metric #(
    .PM_W(PM_W), .INIT_PM(INIT_PM), .G1(4'b1111), .G0(4'b1101)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    logic [7:0]      dec;
    logic [2:0]      best_state;
    logic [PM_W-1:0] best_pm;
  } exp_t;

  exp_t sb_q[$];
  exp_t held;
  int   n_compared = 0;
  int   n_mismatch = 0;
  int   m_pm[8];
  int   enc_state;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatch++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Encoder output for register state s and input u, as a codeword index.
  function automatic int codeword(input int s, input int u);
    logic [3:0] v;
    v = 4'((u << 3) | s);
    return (($countones(v & 4'b1111) & 1) << 1) | ($countones(v & 4'b1101) & 1);
  endfunction

  function automatic void model_reset();
    m_pm[0] = 0;
    for (int i = 1; i < 8; i++) m_pm[i] = INIT_PM;
  endfunction

  // Walks every (state, input) transition forward into its successor
  // {s[1:0],u}, keeping the smallest arriving metric. Predecessors are
  // visited in ascending order, so a tie keeps the one with top bit 0.
  function automatic exp_t model_step(input int b00, input int b01, input int b10, input int b11);
    int   bmv[4];
    int   np[8];
    int   best;
    exp_t e;
    bmv[0] = b00; bmv[1] = b01; bmv[2] = b10; bmv[3] = b11;
    e.dec = '0;
    for (int n = 0; n < 8; n++) np[n] = -1;
    for (int s = 0; s < 8; s++) begin
      for (int u = 0; u < 2; u++) begin
        int n, c;
        n = ((s & 3) << 1) | u;
        c = m_pm[s] + bmv[codeword(s, u)];
        if (np[n] < 0 || c < np[n]) begin
          np[n]    = c;
          e.dec[n] = (s >= 4);
        end
      end
    end
    if (np[0] >= HALF && np[1] >= HALF && np[2] >= HALF && np[3] >= HALF &&
        np[4] >= HALF && np[5] >= HALF && np[6] >= HALF && np[7] >= HALF) begin
      for (int n = 0; n < 8; n++) np[n] -= HALF;
    end
    best = 0;
    for (int n = 1; n < 8; n++) if (np[n] < np[best]) best = n;
    for (int n = 0; n < 8; n++) m_pm[n] = np[n];
    e.best_state = 3'(best);
    e.best_pm    = PM_W'(np[best]);
    return e;
  endfunction

  task automatic applyStimulus(input int b00, input int b01, input int b10, input int b11);
    @(negedge clk);
    bus.init     = 1'b0;
    bus.bm_valid = 1'b1;
    bus.bm00     = 2'(b00);
    bus.bm01     = 2'(b01);
    bus.bm10     = 2'(b10);
    bus.bm11     = 2'(b11);
    sb_q.push_back(model_step(b00, b01, b10, b11));
  endtask

  task automatic idleCycles(input int n);
    repeat (n) begin
      @(negedge clk);
      bus.bm_valid = 1'b0;
      bus.bm00 = 2'($urandom_range(0, 3));
      bus.bm01 = 2'($urandom_range(0, 3));
      bus.bm10 = 2'($urandom_range(0, 3));
      bus.bm11 = 2'($urandom_range(0, 3));
    end
  endtask

  // One step of a randomly encoded message; err_one_in gives the odds of a
  // single flipped received bit. Branch metrics are hard-decision Hamming
  // distances.
  task automatic encodedStep(input int err_one_in);
    int u, rx;
    int bm[4];
    u  = $urandom_range(0, 1);
    rx = codeword(enc_state, u);
    enc_state = ((enc_state & 3) << 1) | u;
    if ($urandom_range(0, err_one_in - 1) == 0) rx = rx ^ (1 << $urandom_range(0, 1));
    for (int c = 0; c < 4; c++) bm[c] = ((rx ^ c) & 1) + (((rx ^ c) >> 1) & 1);
    applyStimulus(bm[0], bm[1], bm[2], bm[3]);
  endtask

  // Monitor: a step pops the scoreboard; a quiet cycle must not leave a step
  // pending and must leave the registered outputs untouched.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        held.dec = '0; held.best_state = '0; held.best_pm = '0;
      end else if (bus.dec_valid) begin
        if (sb_q.size() == 0) begin
          checkOutput("unexpected_dec_valid", 32'(bus.dec_valid), 0);
        end else begin
          e = sb_q.pop_front();
          checkOutput("dec", 32'(bus.dec), 32'(e.dec));
          checkOutput("best_state", 32'(bus.best_state), 32'(e.best_state));
          checkOutput("best_pm", 32'(bus.best_pm), 32'(e.best_pm));
          held = e;
        end
      end else begin
        if (sb_q.size() != 0) begin
          void'(sb_q.pop_front());
          checkOutput("missing_dec_valid", 32'(bus.dec_valid), 1);
        end
        checkOutput("hold_dec", 32'(bus.dec), 32'(held.dec));
        checkOutput("hold_best_state", 32'(bus.best_state), 32'(held.best_state));
        checkOutput("hold_best_pm", 32'(bus.best_pm), 32'(held.best_pm));
      end
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch + 1);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1;
    bus.init = 1'b0; bus.bm_valid = 1'b0;
    bus.bm00 = '0; bus.bm01 = '0; bus.bm10 = '0; bus.bm11 = '0;
    enc_state = 0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("reset_dec_valid", 32'(bus.dec_valid), 0);
    checkOutput("reset_dec", 32'(bus.dec), 0);
    checkOutput("reset_best_state", 32'(bus.best_state), 0);
    checkOutput("reset_best_pm", 32'(bus.best_pm), 0);

    $display("[TB] single step, all-zero codeword");
    applyStimulus(0, 2, 2, 2);
    idleCycles(2);

    $display("[TB] 20-step all-zero message, back to back");
    repeat (20) applyStimulus(0, 2, 2, 2);
    idleCycles(2);

    $display("[TB] tied candidates from reset");
    @(negedge clk); rst = 1'b1; bus.bm_valid = 1'b0;
    @(negedge clk); rst = 1'b0; model_reset(); enc_state = 0;
    repeat (3) applyStimulus(0, 0, 0, 0);
    idleCycles(1);

    $display("[TB] saturating metrics, 200 steps");
    repeat (200) applyStimulus(3, 3, 3, 3);
    idleCycles(2);

    $display("[TB] encoded message with errors, then reset mid-stream");
    @(negedge clk); rst = 1'b1; bus.bm_valid = 1'b0;
    @(negedge clk); rst = 1'b0; model_reset(); enc_state = 0;
    repeat (60) encodedStep(12);
    @(negedge clk);
    rst = 1'b1;
    bus.bm_valid = 1'b1;
    bus.bm00 = 2'($urandom_range(0, 3));
    #1;
    checkOutput("midrst_dec_valid", 32'(bus.dec_valid), 0);
    checkOutput("midrst_dec", 32'(bus.dec), 0);
    checkOutput("midrst_best_state", 32'(bus.best_state), 0);
    checkOutput("midrst_best_pm", 32'(bus.best_pm), 0);
    @(negedge clk); rst = 1'b0; bus.bm_valid = 1'b0;
    model_reset(); enc_state = 0;

    $display("[TB] encoded message, then init mid-stream");
    repeat (30) encodedStep(10);
    @(negedge clk);
    bus.init = 1'b1;
    bus.bm_valid = 1'b1;
    bus.bm00 = 2'($urandom_range(0, 3));
    bus.bm11 = 2'($urandom_range(0, 3));
    model_reset(); enc_state = 0;
    @(negedge clk);
    bus.init = 1'b0;
    bus.bm_valid = 1'b0;
    checkOutput("init_dec_valid", 32'(bus.dec_valid), 0);
    repeat (40) encodedStep(8);

    $display("[TB] raw random metrics with gaps");
    repeat (80) begin
      if ($urandom_range(0, 3) == 0) idleCycles($urandom_range(1, 3));
      applyStimulus($urandom_range(0, 3), $urandom_range(0, 3),
                    $urandom_range(0, 3), $urandom_range(0, 3));
    end
    idleCycles(3);
    checkOutput("queue_drained", 32'(sb_q.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch);
    $finish;
  end

endmodule
